mux_n_rr_pipe: RTL and testbench
================================

// Module: mux_n_rr_pipe
//
// PURPOSE
//  Parametrised N-input, W-bit multiplexor with a one-entry registered output
//  and val/rdy handshakes on every port. It is the sequential successor to the
//  combinational two-input mux: it merges several message streams onto one
//  output channel. The selection mode is fixed per instance:
//   - round-robin arbitration, or
//   - external select.
//
// PARAMETERS
//  p_nbits    4  width of each message
//  p_ninputs  2  number of input channels (>=2; need not be a power of two)
//  p_rr       1  1 = round-robin arbitration; 0 = external sel port chooses input
//
// PORTS
//  clk       in   1                  clock, all state on rising edge
//  reset_n   in   1                  reset, asynchronous, active-low
//  in_val    in   p_ninputs          per-input valid
//  in_rdy    out  p_ninputs          per-input ready (at most one bit high)
//  in_msg    in   p_ninputs*p_nbits  packed messages; input i = [i*p_nbits +: p_nbits]
//  sel       in   $clog2(p_ninputs)  external select; ignored when p_rr=1
//  out_val   out  1                  output register holds a valid message
//  out_rdy   in   1                  downstream ready
//  out_msg   out  p_nbits            registered message
//  out_src   out  $clog2(p_ninputs)  index of the input that supplied out_msg
//
// BEHAVIOUR
//  - Reset (reset_n=0, async): out_val=0, out_msg=0, out_src=0, RR pointer=0.
//    in_rdy=0 while reset is asserted. A message held at reset is discarded.
//  - Transfers: a transfer on any port occurs when val&rdy are high at a clk edge.
//  - can_accept = !out_val | out_rdy. The stage is full-throughput: it accepts a
//    new message in the same cycle the held one drains.
//  - Grant, p_rr=1: the lowest index i, counted cyclically from ptr, with in_val[i]=1.
//  - Grant, p_rr=0: grant=sel, only if in_val[sel]=1. sel >= p_ninputs grants nothing.
//  - in_rdy[i] = can_accept & grant[i]. in_rdy is one-hot or zero.
//  - On an input transfer from g: out_msg<=in_msg[g], out_src<=g, out_val<=1.
//  - Out transfer without an input transfer: out_val<=0. out_msg and out_src hold.
//  - Latency is exactly 1 cycle from input transfer to out_val.
//  - Combinational paths: none from in_* to out_*. in_rdy depends on
//    in_val/sel/out_rdy.
//  - RR pointer: after a transfer from g, ptr <= (g+1 == p_ninputs) ? 0 : g+1.
//    With no transfer it is unchanged. ptr is unused when p_rr=0.
//  - Backpressure (out_val=1, out_rdy=0): all in_rdy=0. out_msg and out_src hold
//    stable. ptr is unchanged.
//  - No in_val asserted: no grant, ptr unchanged. out_val falls after the drain.
//  - Starvation bound (p_rr=1): a continuously valid input is granted within
//    p_ninputs accepted transfers.
//  - Reset mid-stream: takes effect immediately (async). The first grant after
//    reset goes to the lowest valid index.
//
// TESTING
//  - Reset: hold reset_n=0 with all in_val=1 -> out_val=0, out_msg=0, in_rdy=0.
//    Release -> first accepted input is 0.
//  - RR fairness: N=3, W=8, all in_val=1, msgs 0x11/0x22/0x33, out_rdy=1.
//    Expect out_msg sequence 11,22,33,11,... and out_src 0,1,2,0, one per cycle.
//  - RR skip and wrap: N=3, in_val=3'b101 continuously.
//    Expect out_src alternating 0,2,0,2. Input 1 is never granted.
//  - Backpressure: hold out_rdy=0 for 4 cycles after msg 0xA5.
//    out_msg stays 0xA5 and in_rdy=0. On release, the next input is accepted
//    in that same cycle.
//  - Select mode: p_rr=0, sel=1, in_val=2'b11, in_msg {0x5,0x9}, W=4.
//    Expect only in_rdy[1]=1 and out_msg=0x5.
//    With sel=1 and in_val=2'b01 -> no transfer.
//  - Async reset mid-operation: assert reset_n low between clock edges while
//    out_val=1. out_val drops to 0 at once, with no clock edge required.

Source files
------------

// File: rtl/mux_n_rr_pipe_if.sv
// Handshake bundle for mux_n_rr_pipe: N val/rdy input channels merged onto one
// registered val/rdy output channel.
interface mux_n_rr_pipe_if #(
    parameter int p_nbits   = 4,
    parameter int p_ninputs = 2
);
    localparam int SW = $clog2(p_ninputs);

    logic [p_ninputs-1:0]         in_val;
    logic [p_ninputs-1:0]         in_rdy;
    logic [p_ninputs*p_nbits-1:0] in_msg;
    logic [SW-1:0]                sel;
    logic                         out_val;
    logic                         out_rdy;
    logic [p_nbits-1:0]           out_msg;
    logic [SW-1:0]                out_src;

    modport slave (
        input  in_val, in_msg, sel, out_rdy,
        output in_rdy, out_val, out_msg, out_src
    );

    modport master (
        output in_val, in_msg, sel, out_rdy,
        input  in_rdy, out_val, out_msg, out_src
    );
endinterface

// File: rtl/mux_n_rr_pipe.sv
// N-input val/rdy mux with a one-entry output register; input chosen by
// round-robin arbitration (p_rr=1) or by the external sel port (p_rr=0).
module mux_n_rr_pipe #(
    parameter int p_nbits   = 4,
    parameter int p_ninputs = 2,
    parameter bit p_rr      = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    mux_n_rr_pipe_if.slave  bus
);
    localparam int SW = $clog2(p_ninputs);

    logic [p_ninputs-1:0][p_nbits-1:0] msgs;
    logic [SW-1:0]                     ptr;
    logic [SW-1:0]                     gidx;
    logic [SW:0]                       cand;
    logic                              found;
    logic                              can_accept;
    logic                              xfer_in;

    // Packed reshape: msgs[i] is in_msg[i*p_nbits +: p_nbits].
    assign msgs       = bus.in_msg;
    assign can_accept = !bus.out_val || bus.out_rdy;
    assign xfer_in    = found && can_accept;

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        if (p_rr) begin
            // Scan from ptr with wraparound; ptr+k < 2*p_ninputs so one subtract suffices.
            for (int k = 0; k < p_ninputs; k++) begin
                cand = {1'b0, ptr} + (SW+1)'(k);
                if (cand >= (SW+1)'(p_ninputs))
                    cand = cand - (SW+1)'(p_ninputs);
                if (!found && bus.in_val[cand[SW-1:0]]) begin
                    found = 1'b1;
                    gidx  = cand[SW-1:0];
                end
            end
        end else if (int'(bus.sel) < p_ninputs) begin
            found = bus.in_val[bus.sel];
            gidx  = bus.sel;
        end
    end

    always_comb begin
        bus.in_rdy = '0;
        if (xfer_in && reset_n)
            bus.in_rdy[gidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_val <= 1'b0;
            bus.out_msg <= '0;
            bus.out_src <= '0;
            ptr         <= '0;
        end else if (xfer_in) begin
            bus.out_val <= 1'b1;
            bus.out_msg <= msgs[gidx];
            bus.out_src <= gidx;
            if (p_rr)
                ptr <= (int'(gidx) == p_ninputs - 1) ? '0 : gidx + 1'b1;
        end else if (bus.out_val && bus.out_rdy) begin
            bus.out_val <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_n_rr_pipe.sv
// Bench for mux_n_rr_pipe: a round-robin instance (N=3, W=8) and a select
// instance (N=2, W=4), each tracked by a reference model and a scoreboard.
module tb_mux_n_rr_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mux_n_rr_pipe_if #(.p_nbits(8), .p_ninputs(3)) rr_bus ();
    mux_n_rr_pipe_if #(.p_nbits(4), .p_ninputs(2)) sel_bus ();

    mux_n_rr_pipe #(.p_nbits(8), .p_ninputs(3), .p_rr(1'b1)) u_rr (
        .clk(clk), .reset_n(reset_n), .bus(rr_bus.slave)
    );
    mux_n_rr_pipe #(.p_nbits(4), .p_ninputs(2), .p_rr(1'b0)) u_sel (
        .clk(clk), .reset_n(reset_n), .bus(sel_bus.slave)
    );

    typedef struct packed { logic [7:0] msg; logic [1:0] src; } rr_exp_t;
    typedef struct packed { logic [3:0] msg; logic       src; } sel_exp_t;

    rr_exp_t  rr_q[$];
    sel_exp_t sel_q[$];
    int       rr_src_log[$];
    int       rr_msg_log[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       rr_g1_cnt = 0;
    int       rr_ptr_m = 0;
    bit       rr_full_m = 1'b0;
    bit       sel_full_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin reference: evaluated mid-cycle, models the next rising edge.
    always @(negedge clk) begin
        int      g;
        int      idx;
        rr_exp_t e;
        if (!reset_n) begin
            rr_ptr_m  = 0;
            rr_full_m = 1'b0;
            rr_q.delete();
        end else begin
            chk("rr_out_val", rr_bus.out_val, rr_full_m);
            if (rr_bus.out_val && rr_bus.out_rdy) begin
                chk("rr_q_size", rr_q.size(), 1);
                if (rr_q.size() > 0) begin
                    e = rr_q.pop_front();
                    chk("rr_out_msg", rr_bus.out_msg, e.msg);
                    chk("rr_out_src", rr_bus.out_src, e.src);
                end
                rr_src_log.push_back(int'(rr_bus.out_src));
                rr_msg_log.push_back(int'(rr_bus.out_msg));
            end
            if (rr_bus.in_rdy[1]) rr_g1_cnt++;
            g = -1;
            if (!rr_full_m || rr_bus.out_rdy) begin
                for (int k = 0; k < 3; k++) begin
                    idx = (rr_ptr_m + k) % 3;
                    if (g < 0 && rr_bus.in_val[idx[1:0]]) g = idx;
                end
            end
            chk("rr_in_rdy", rr_bus.in_rdy, (g >= 0) ? (3'b001 << g) : 3'b000);
            if (g >= 0) begin
                e.msg = rr_bus.in_msg[g*8 +: 8];
                e.src = g[1:0];
                rr_q.push_back(e);
                rr_ptr_m  = (g + 1) % 3;
                rr_full_m = 1'b1;
            end else if (rr_full_m && rr_bus.out_rdy) begin
                rr_full_m = 1'b0;
            end
        end
    end

    // Select-mode reference.
    always @(negedge clk) begin
        int       g;
        sel_exp_t e;
        if (!reset_n) begin
            sel_full_m = 1'b0;
            sel_q.delete();
        end else begin
            chk("sel_out_val", sel_bus.out_val, sel_full_m);
            if (sel_bus.out_val && sel_bus.out_rdy) begin
                chk("sel_q_size", sel_q.size(), 1);
                if (sel_q.size() > 0) begin
                    e = sel_q.pop_front();
                    chk("sel_out_msg", sel_bus.out_msg, e.msg);
                    chk("sel_out_src", sel_bus.out_src, e.src);
                end
            end
            g = -1;
            if ((!sel_full_m || sel_bus.out_rdy) && sel_bus.in_val[sel_bus.sel])
                g = int'(sel_bus.sel);
            chk("sel_in_rdy", sel_bus.in_rdy, (g >= 0) ? (2'b01 << g) : 2'b00);
            if (g >= 0) begin
                e.msg = sel_bus.in_msg[g*4 +: 4];
                e.src = g[0];
                sel_q.push_back(e);
                sel_full_m = 1'b1;
            end else if (sel_full_m && sel_bus.out_rdy) begin
                sel_full_m = 1'b0;
            end
        end
    end

    initial begin
        int fair_src[4] = '{0, 1, 2, 0};
        int fair_msg[4] = '{'h11, 'h22, 'h33, 'h11};
        int skip_src[4] = '{0, 2, 0, 2};

        rr_bus.in_val   = 3'b111;
        rr_bus.in_msg   = {8'h33, 8'h22, 8'h11};
        rr_bus.sel      = '0;
        rr_bus.out_rdy  = 1'b1;
        sel_bus.in_val  = 2'b11;
        sel_bus.in_msg  = {4'h5, 4'h9};
        sel_bus.sel     = 1'b0;
        sel_bus.out_rdy = 1'b1;

        // Reset held with all inputs valid.
        repeat (3) @(posedge clk);
        #4;
        chk("rst_out_val", rr_bus.out_val, 0);
        chk("rst_out_msg", rr_bus.out_msg, 0);
        chk("rst_in_rdy", rr_bus.in_rdy, 0);
        chk("rst_sel_in_rdy", sel_bus.in_rdy, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rr_src_log.delete();
        rr_msg_log.delete();

        // Fairness: six grants bring the pointer back to 0.
        repeat (6) @(posedge clk);
        #1;
        rr_bus.in_val = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("fair_len", rr_src_log.size(), 6);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair_src%0d", i), rr_src_log[i], fair_src[i]);
            chk($sformatf("fair_msg%0d", i), rr_msg_log[i], fair_msg[i]);
        end

        // Skip and wrap with input 1 idle.
        rr_src_log.delete();
        rr_msg_log.delete();
        rr_g1_cnt = 0;
        rr_bus.in_val = 3'b101;
        repeat (6) @(posedge clk);
        #1;
        rr_bus.in_val = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("skip_src%0d", i), rr_src_log[i], skip_src[i]);
        chk("skip_g1_cnt", rr_g1_cnt, 0);

        // Backpressure after capturing 0xA5.
        rr_bus.in_msg = {8'h33, 8'h22, 8'hA5};
        rr_bus.in_val = 3'b001;
        @(posedge clk); #1;
        rr_bus.out_rdy = 1'b0;
        rr_bus.in_msg  = {8'h33, 8'h22, 8'h5A};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk($sformatf("bp_msg%0d", i), rr_bus.out_msg, 8'hA5);
            chk($sformatf("bp_rdy%0d", i), rr_bus.in_rdy, 3'b000);
        end
        @(posedge clk); #1;
        rr_bus.out_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", rr_bus.in_rdy, 3'b001);
        @(posedge clk); #2;
        chk("bp_next_msg", rr_bus.out_msg, 8'h5A);
        rr_bus.in_val = 3'b000;

        // Select mode.
        sel_bus.sel    = 1'b1;
        sel_bus.in_val = 2'b11;
        @(posedge clk); #1;
        chk("sel_rdy", sel_bus.in_rdy, 2'b10);
        @(posedge clk); #2;
        chk("sel_msg", sel_bus.out_msg, 4'h5);
        chk("sel_src", sel_bus.out_src, 1);
        sel_bus.in_val = 2'b01;
        #1;
        chk("sel_none_rdy", sel_bus.in_rdy, 2'b00);
        @(posedge clk); #2;
        chk("sel_drained", sel_bus.out_val, 0);

        // Async reset between edges while the output is full.
        rr_bus.in_msg = {8'h33, 8'h22, 8'h11};
        rr_bus.in_val = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_pre_val", rr_bus.out_val, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_val", rr_bus.out_val, 0);
        chk("arst_out_msg", rr_bus.out_msg, 0);
        chk("arst_in_rdy", rr_bus.in_rdy, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rr_bus.in_val = 3'b110;
        #1;
        chk("arst_first_grant", rr_bus.in_rdy, 3'b010);
        repeat (4) @(posedge clk);
        #1;
        rr_bus.in_val  = 3'b000;
        sel_bus.in_val = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("end_rr_q", rr_q.size(), 0);
        chk("end_sel_q", sel_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
